// File: rtl/sram_burst_master.sv
// sram_burst_master
//   Burst initiator for a single-port synchronous SRAM that samples its pins
//   on the falling clock edge. Accepts (addr, len, dir) burst commands and
//   then walks the SRAM one beat at a time. Write data arrives on a
//   valid/ready stream. Read data leaves on a valid/ready stream and may be
//   held off by backpressure.
//
//   Ports
//     Clk_In, Reset_In          clock (posedge), async active-high reset
//     Cmd_Valid/Ready           command handshake; Ready only while idle
//     Cmd_Write/Addr/Len        direction (1=write), start address, beats-1
//     Wr_Data_Valid/Ready/Data  write stream; Ready only in WRITE
//     Rd_Data_Valid/Ready/Data  read stream; word held until accepted
//     Busy, Done                not idle / one-cycle completion pulse
//     Sram_*                    SRAM pins (Address, Data_In, Write_Enable,
//                               Read_Enable out; Data_Out in)
module sram_burst_master #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Cmd_Valid,
    output logic                  Cmd_Ready,
    input  logic                  Cmd_Write,
    input  logic [ADDR_WIDTH-1:0] Cmd_Addr,
    input  logic [LEN_WIDTH-1:0]  Cmd_Len,
    input  logic                  Wr_Data_Valid,
    output logic                  Wr_Data_Ready,
    input  logic [DATA_WIDTH-1:0] Wr_Data,
    output logic                  Rd_Data_Valid,
    input  logic                  Rd_Data_Ready,
    output logic [DATA_WIDTH-1:0] Rd_Data,
    output logic                  Busy,
    output logic                  Done,
    output logic [ADDR_WIDTH-1:0] Sram_Address,
    output logic [DATA_WIDTH-1:0] Sram_Data_In,
    output logic                  Sram_Write_Enable,
    output logic                  Sram_Read_Enable,
    input  logic [DATA_WIDTH-1:0] Sram_Data_Out
);

    typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_OUT, FINISH} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;   // address of the next beat
    logic [LEN_WIDTH-1:0]  count;  // beats remaining after the current one

    logic wr_hs;

    assign Cmd_Ready     = (state == IDLE);
    assign Wr_Data_Ready = (state == WRITE);
    assign Busy          = (state != IDLE);
    assign wr_hs         = Wr_Data_Valid & Wr_Data_Ready;

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state             <= IDLE;
            addr              <= '0;
            count             <= '0;
            Rd_Data           <= '0;
            Rd_Data_Valid     <= 1'b0;
            Done              <= 1'b0;
            Sram_Address      <= '0;
            Sram_Data_In      <= '0;
            Sram_Write_Enable <= 1'b0;
            Sram_Read_Enable  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Cmd_Valid) begin
                        addr  <= Cmd_Addr;
                        count <= Cmd_Len;
                        if (Cmd_Write) begin
                            state <= WRITE;
                        end else begin
                            // Present the first read request immediately
                            state            <= RD_REQ;
                            Sram_Read_Enable <= 1'b1;
                            Sram_Address     <= Cmd_Addr;
                        end
                    end
                end
                WRITE: begin
                    // Write enable is high for exactly the cycle after each
                    // accepted word, so back-to-back words give 1 beat/clk.
                    Sram_Write_Enable <= wr_hs;
                    if (wr_hs) begin
                        Sram_Address <= addr;
                        Sram_Data_In <= Wr_Data;
                        addr         <= addr + ADDR_WIDTH'(1);
                        count        <= count - LEN_WIDTH'(1);
                        if (count == '0) begin
                            state <= FINISH;
                            Done  <= 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    // SRAM drove Data_Out at the preceding negedge
                    Rd_Data          <= Sram_Data_Out;
                    Rd_Data_Valid    <= 1'b1;
                    Sram_Read_Enable <= 1'b0;
                    state            <= RD_OUT;
                end
                RD_OUT: begin
                    if (Rd_Data_Ready) begin
                        Rd_Data_Valid <= 1'b0;
                        if (count == '0) begin
                            state <= FINISH;
                            Done  <= 1'b1;
                        end else begin
                            addr             <= addr + ADDR_WIDTH'(1);
                            count            <= count - LEN_WIDTH'(1);
                            Sram_Address     <= addr + ADDR_WIDTH'(1);
                            Sram_Read_Enable <= 1'b1;
                            state            <= RD_REQ;
                        end
                    end
                end
                FINISH: begin
                    // Last write beat is still on the pins during this cycle
                    Sram_Write_Enable <= 1'b0;
                    Sram_Read_Enable  <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
